// File: rtl/svga_pkg.sv
// Shared timing constants and coordinate type for the raster generators.
package svga_pkg;

  // Coordinate type wide enough for the 800x600@72 totals (1040 x 666).
  typedef logic [10:0] coord_t;
  localparam int DEF_COORD_W = $bits(coord_t);

  // 800x600@72 (50 MHz pixel clock)
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 56;
  localparam int SVGA_H_SYNC   = 120;
  localparam int SVGA_H_BP     = 64;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 37;
  localparam int SVGA_V_SYNC   = 6;
  localparam int SVGA_V_BP     = 23;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int VGA_H_ACTIVE  = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_V_ACTIVE  = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;

  // Total length of a line or frame from its four segments.
  function automatic int seg_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/svga_timing_gen_if.sv
// Raster output bundle from the timing generator to the renderers.
// pix_en (a plain port on the generator) qualifies every clk: there is no
// ready/backpressure path; a consumer treats a clk as one pixel exactly when
// pix_en=1, and row/col/strobes describe the pixel presented in that clk.
interface svga_timing_gen_if
  import svga_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int FCNT_W  = 16
);
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               hs;
  logic               vs;
  logic               blank;
  logic               de;
  logic               line_start;
  logic               frame_start;
  logic [FCNT_W-1:0]  frame_count;

  modport master (
    output row, col, hs, vs, blank, de, line_start, frame_start, frame_count
  );

  modport slave (
    input row, col, hs, vs, blank, de, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/svga_timing_gen_pipe_delay.sv
// Enable-gated shift register; DEPTH=0 degenerates to a wire.
module pipe_delay #(
  parameter int               WIDTH     = 4,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, en};
    assign dout = din;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per enabled clk; every stage resets to RESET_VAL.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
      end else if (en) begin
        stage_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/svga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync/blank
// decode, a pixel-aligned delay line for the sync bundle, strobes and a
// completed-frame counter.
module svga_timing_gen
  import svga_pkg::*;
#(
  parameter int H_ACTIVE = SVGA_H_ACTIVE,
  parameter int H_FP     = SVGA_H_FP,
  parameter int H_SYNC   = SVGA_H_SYNC,
  parameter int H_BP     = SVGA_H_BP,
  parameter int V_ACTIVE = SVGA_V_ACTIVE,
  parameter int V_FP     = SVGA_V_FP,
  parameter int V_SYNC   = SVGA_V_SYNC,
  parameter int V_BP     = SVGA_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COORD_W  = DEF_COORD_W,
  parameter int LATENCY  = 2,
  parameter int FCNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  svga_timing_gen_if.master vid
);

  localparam int H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint COORD_MAX = (64'd1 << COORD_W) - 1;

  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0
      || longint'(H_TOTAL - 1) > COORD_MAX || longint'(V_TOTAL - 1) > COORD_MAX
      || LATENCY < 0 || LATENCY > 8) begin : g_param_check
    $error("svga_timing_gen: zero porch/sync, counter too narrow, or LATENCY outside 0..8");
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  // Sync bundle order in the delay line: {hs, vs, blank, de}.
  localparam logic [3:0] SYNC_IDLE = {~HS_POL, ~VS_POL, 1'b1, 1'b0};

  logic [COORD_W-1:0] col_q;
  logic [COORD_W-1:0] row_q;
  logic [FCNT_W-1:0]  fcnt_q;
  logic               col_wrap;
  logic               row_wrap;
  logic               h_blank, v_blank, blank_raw;
  logic               hs_raw, vs_raw;
  logic               hs_lvl, vs_lvl;
  logic [3:0]         sync_raw;
  logic [3:0]         sync_dly;

  assign col_wrap = (col_q == H_LAST);
  assign row_wrap = (row_q == V_LAST);

  // Pixel counter: advances once per enabled clk, wraps at end of line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        col_q <= '0;
    else if (pix_en)  col_q <= col_wrap ? '0 : col_q + 1'b1;
  end

  // Line counter: advances on the enabled clk where the pixel counter wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   row_q <= '0;
    else if (pix_en && col_wrap) row_q <= row_wrap ? '0 : row_q + 1'b1;
  end

  // Completed-frame counter: bumps when both counters wrap together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               fcnt_q <= '0;
    else if (pix_en && col_wrap && row_wrap) fcnt_q <= fcnt_q + 1'b1;
  end

  // Raw decode of sync and blanking windows from the undelayed counters.
  always_comb begin
    h_blank   = (col_q >= H_ACT);
    v_blank   = (row_q >= V_ACT);
    blank_raw = h_blank | v_blank;
    hs_raw    = (col_q >= HS_START) && (col_q < HS_END);
    vs_raw    = (row_q >= VS_START) && (row_q < VS_END);
    hs_lvl    = hs_raw ? HS_POL : ~HS_POL;
    vs_lvl    = vs_raw ? VS_POL : ~VS_POL;
    sync_raw  = {hs_lvl, vs_lvl, blank_raw, ~blank_raw};
  end

  // Delay counts pixels, not clks, so it stays aligned with the renderer pipe.
  pipe_delay #(
    .WIDTH     (4),
    .DEPTH     (LATENCY),
    .RESET_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .din   (sync_raw),
    .dout  (sync_dly)
  );

  assign vid.row         = row_q;
  assign vid.col         = col_q;
  assign vid.hs          = sync_dly[3];
  assign vid.vs          = sync_dly[2];
  assign vid.blank       = sync_dly[1];
  assign vid.de          = sync_dly[0];
  assign vid.line_start  = pix_en & (col_q == '0);
  assign vid.frame_start = pix_en & (col_q == '0) & (row_q == '0);
  assign vid.frame_count = fcnt_q;

endmodule
